// File: rtl/nxn_multiplier_if.sv
// -----------------------------------------------------------------------------
// nxn_multiplier_if
// Operand/product bundle for the N x N unsigned multiplier.
//   multiplicand : N bits,  operand A  (driven by master)
//   multiplier   : N bits,  operand B  (driven by master)
//   product      : 2N bits, registered A*B (driven by slave)
// No handshake: a new operand pair may be presented every cycle.
// -----------------------------------------------------------------------------
interface nxn_multiplier_if #(
    parameter int N = 4
);
    logic [N-1:0]   multiplicand;
    logic [N-1:0]   multiplier;
    logic [2*N-1:0] product;

    modport master (
        output multiplicand,
        output multiplier,
        input  product
    );

    modport slave (
        input  multiplicand,
        input  multiplier,
        output product
    );
endinterface

// File: rtl/nxn_multiplier.sv
// -----------------------------------------------------------------------------
// nxn_multiplier
// Unsigned N x N array multiplier with a registered 2N-bit product.
//   clk  : system clock, rising edge
//   rst  : synchronous, active-high; clears the product register
//   bus  : slave side of nxn_multiplier_if
//          (multiplicand, multiplier in; product out, latency 1 cycle)
// The core is an AND-gate partial-product plane summed by N-1 rows of
// half/full-adder cells; the registered output removes any combinational
// path from operands to product.
// -----------------------------------------------------------------------------
module nxn_multiplier #(
    parameter int N = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    nxn_multiplier_if.slave       bus
);

    // Partial-product plane: w_pp[j][i] = multiplicand[i] & multiplier[j]
    logic [N-1:0]   w_pp [N];
    logic [2*N-1:0] w_core;
    logic [2*N-1:0] r_product;

    // Working variables of the adder array
    logic [N-1:0]   w_row_sum;
    logic           w_row_cout;
    logic [N-1:0]   w_add_a;
    logic [N-1:0]   w_next_sum;
    logic           w_carry;

    genvar gi, gk;
    generate
        for (gi = 0; gi < N; gi++) begin : g_pp_row
            for (gk = 0; gk < N; gk++) begin : g_pp_bit
                assign w_pp[gi][gk] = bus.multiplicand[gk] & bus.multiplier[gi];
            end
        end
    endgenerate

    // Adder array. Each row adds the next partial-product row to the upper
    // N bits of the running sum (previous sum shifted right by one with the
    // previous row's carry-out as its new MSB). The LSB that falls out of
    // each row is a finished product bit. Cell 0 of each row has no carry-in
    // and is therefore a half adder; the rest are full adders with the carry
    // rippling across the row.
    always_comb begin
        w_core     = '0;
        w_add_a    = '0;
        w_next_sum = '0;
        w_carry    = 1'b0;
        w_row_sum  = w_pp[0];
        w_row_cout = 1'b0;
        w_core[0]  = w_pp[0][0];
        for (int j = 1; j < N; j++) begin
            w_add_a = {w_row_cout, w_row_sum[N-1:1]};
            w_carry = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (i == 0) begin
                    w_next_sum[i] = w_add_a[i] ^ w_pp[j][i];
                    w_carry       = w_add_a[i] & w_pp[j][i];
                end else begin
                    w_next_sum[i] = w_add_a[i] ^ w_pp[j][i] ^ w_carry;
                    w_carry       = (w_add_a[i] & w_pp[j][i]) |
                                    (w_add_a[i] & w_carry)    |
                                    (w_pp[j][i] & w_carry);
                end
            end
            w_row_sum  = w_next_sum;
            w_row_cout = w_carry;
            w_core[j]  = w_row_sum[0];
        end
        // Remaining high half: final row's upper bits plus its carry-out
        w_core[2*N-1:N] = {w_row_cout, w_row_sum[N-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_product <= '0;
        end else begin
            r_product <= w_core;
        end
    end

    assign bus.product = r_product;

endmodule

// File: tb/tb_nxn_multiplier.sv
// -----------------------------------------------------------------------------
// tb_nxn_multiplier
// Scoreboard bench for nxn_multiplier at N=4 and N=8. Drivers push the
// expected product (plain arithmetic) into per-instance queues; monitors pop
// and compare 1 time unit after each rising edge, then re-check the held
// value after the drivers have disturbed the operands mid-cycle.
// -----------------------------------------------------------------------------
module tb_nxn_multiplier;

    typedef struct {
        logic        r;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } txn_t;

    logic clk = 1'b0;
    logic rst4 = 1'b1;
    logic rst8 = 1'b1;

    always #5 clk = ~clk;

    nxn_multiplier_if #(.N(4)) bus4 ();
    nxn_multiplier_if #(.N(8)) bus8 ();

    nxn_multiplier #(.N(4)) u_dut4 (
        .clk (clk),
        .rst (rst4),
        .bus (bus4)
    );

    nxn_multiplier #(.N(8)) u_dut8 (
        .clk (clk),
        .rst (rst8),
        .bus (bus8)
    );

    txn_t q4[$];
    txn_t q8[$];
    int   passed = 0;
    int   total  = 0;

    // ---------------- drivers ----------------
    task automatic drive4(input logic r, input logic [3:0] a, input logic [3:0] b);
        txn_t t;
        @(negedge clk);
        rst4 = r;
        bus4.multiplicand = a;
        bus4.multiplier   = b;
        t.r   = r;
        t.a   = {4'd0, a};
        t.b   = {4'd0, b};
        t.exp = r ? 16'd0 : 16'(int'(a) * int'(b));
        q4.push_back(t);
        @(posedge clk);
        #3;
        // Disturb operands after the capture edge; product must not follow.
        bus4.multiplicand = 4'($urandom);
        bus4.multiplier   = 4'($urandom);
    endtask

    task automatic drive8(input logic r, input logic [7:0] a, input logic [7:0] b);
        txn_t t;
        @(negedge clk);
        rst8 = r;
        bus8.multiplicand = a;
        bus8.multiplier   = b;
        t.r   = r;
        t.a   = a;
        t.b   = b;
        t.exp = r ? 16'd0 : 16'(int'(a) * int'(b));
        q8.push_back(t);
        @(posedge clk);
        #3;
        bus8.multiplicand = 8'($urandom);
        bus8.multiplier   = 8'($urandom);
    endtask

    // ---------------- monitors ----------------
    initial begin : mon4
        txn_t t;
        logic have;
        forever begin
            @(posedge clk);
            #1;
            have = 1'b0;
            if (q4.size() > 0) begin
                t = q4.pop_front();
                have = 1'b1;
                total++;
                if (bus4.product !== t.exp[7:0])
                    $display("FAIL prod4 rst=%0b %0d*%0d got=%0d want=%0d", t.r, t.a, t.b, bus4.product, t.exp[7:0]);
                else begin
                    passed++;
                    $display("n4 rst=%0b %0d*%0d -> %0d", t.r, t.a, t.b, bus4.product);
                end
            end
            #3;
            if (have) begin
                total++;
                if (bus4.product !== t.exp[7:0])
                    $display("FAIL hold4 %0d*%0d got=%0d want=%0d", t.a, t.b, bus4.product, t.exp[7:0]);
                else
                    passed++;
            end
        end
    end

    initial begin : mon8
        txn_t t;
        logic have;
        forever begin
            @(posedge clk);
            #1;
            have = 1'b0;
            if (q8.size() > 0) begin
                t = q8.pop_front();
                have = 1'b1;
                total++;
                if (bus8.product !== t.exp)
                    $display("FAIL prod8 rst=%0b %0d*%0d got=%0d want=%0d", t.r, t.a, t.b, bus8.product, t.exp);
                else begin
                    passed++;
                    $display("n8 rst=%0b %0d*%0d -> %0d", t.r, t.a, t.b, bus8.product);
                end
            end
            #3;
            if (have) begin
                total++;
                if (bus8.product !== t.exp)
                    $display("FAIL hold8 %0d*%0d got=%0d want=%0d", t.a, t.b, bus8.product, t.exp);
                else
                    passed++;
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout total=%0d passed=%0d", total, passed);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        bus4.multiplicand = 4'hF;
        bus4.multiplier   = 4'hF;
        bus8.multiplicand = 8'hFF;
        bus8.multiplier   = 8'hFF;

        // Reset with maximal operands, then release with 3*5
        drive4(1'b1, 4'hF, 4'hF);
        drive4(1'b1, 4'hF, 4'hF);
        drive4(1'b0, 4'd3, 4'd5);

        // Boundaries
        drive4(1'b0, 4'd0,  4'd13);
        drive4(1'b0, 4'd1,  4'd9);
        drive4(1'b0, 4'd15, 4'd1);
        drive4(1'b0, 4'd15, 4'd15);
        drive4(1'b0, 4'd8,  4'd8);

        // Back-to-back
        drive4(1'b0, 4'd7,  4'd7);
        drive4(1'b0, 4'd2,  4'd9);
        drive4(1'b0, 4'd15, 4'd14);

        // Exhaustive sweep with a one-edge reset injected at 12*11
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                if (i == 12 && j == 11)
                    drive4(1'b1, 4'(i), 4'(j));
                else
                    drive4(1'b0, 4'(i), 4'(j));
            end
        end

        // N=8: reset, boundaries, random sweep
        drive8(1'b1, 8'hFF, 8'hFF);
        drive8(1'b0, 8'd255, 8'd255);
        drive8(1'b0, 8'd128, 8'd2);
        drive8(1'b0, 8'd0,   8'd200);
        drive8(1'b0, 8'd1,   8'd173);
        for (int k = 0; k < 1000; k++)
            drive8(1'b0, 8'($urandom), 8'($urandom));

        repeat (3) @(posedge clk);
        #6;
        total++;
        if (q4.size() + q8.size() != 0)
            $display("FAIL drain leftover=%0d want=0", q4.size() + q8.size());
        else
            passed++;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
